// File: rtl/program_loader.sv
// program_loader: assembles the UART byte stream into 32-bit words and paces them into fetch's loader port.
// Optional trailer checksum is compiled in with PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned INST_MEM_WIDTH = 2,
  parameter int unsigned MIN_GAP        = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] input_data,
  output logic        input_valid,
  output logic        input_start,
  output logic        input_end,
  output logic        busy,
  output logic        oversize,
  output logic        overrun,
  output logic        checksum_err
);

  localparam int unsigned      GAP_W    = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [32:0]      CAPACITY = 33'(1) << INST_MEM_WIDTH;

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_GAP_END
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift_q;
  logic [GAP_W-1:0] gap_q;
  logic [31:0]      remaining;
  logic [31:0]      pend_word;
  logic             pend_full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]      csum_acc;
`endif

  logic        accept_c;
  logic        word_done_c;
  logic        gap_done_c;
  logic        issue_c;
  logic [31:0] new_word_c;
  logic [31:0] eff_word_c;

  // A word completing in the issue cycle bypasses (or replaces) the pending slot.
  always_comb begin
    accept_c    = rx_valid && (state != S_GAP_END);
    word_done_c = accept_c && (byte_cnt == 2'd3);
    new_word_c  = {shift_q, rx_data};
    gap_done_c  = (gap_q == GAP_MAX);
    eff_word_c  = word_done_c ? new_word_c : pend_word;
    issue_c     = (state == S_DATA) && (word_done_c || pend_full) && gap_done_c;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HDR;
      byte_cnt    <= 2'd0;
      shift_q     <= 24'd0;
      gap_q       <= '0;
      remaining   <= 32'd0;
      pend_word   <= 32'd0;
      pend_full   <= 1'b0;
      input_data  <= 32'd0;
      input_valid <= 1'b0;
      input_start <= 1'b0;
      input_end   <= 1'b0;
      busy        <= 1'b0;
      oversize    <= 1'b0;
      overrun     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_acc     <= 32'd0;
      checksum_err <= 1'b0;
`endif
    end else begin
      input_start <= 1'b0;
      input_end   <= 1'b0;

      if (accept_c) begin
        shift_q  <= new_word_c[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Cycles since the last start/toggle, saturating at MIN_GAP.
      if (!gap_done_c) gap_q <= gap_q + GAP_W'(1);

      case (state)
        S_HDR: begin
          if (rx_valid)                busy <= 1'b1;
          else if (byte_cnt == 2'd0)   busy <= 1'b0;
          if (word_done_c) begin
            remaining   <= new_word_c;
            input_start <= 1'b1;
            oversize    <= ({1'b0, new_word_c} > CAPACITY);
            overrun     <= 1'b0;
            pend_full   <= 1'b0;
            gap_q       <= GAP_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum_err <= 1'b0;
            csum_acc     <= 32'd0;
`endif
            state <= (new_word_c == 32'd0) ? S_GAP_END : S_DATA;
          end
        end

        S_DATA: begin
          if (word_done_c && pend_full) overrun <= 1'b1;
          if (issue_c) begin
            input_data  <= eff_word_c;
            input_valid <= ~input_valid;
            remaining   <= remaining - 32'd1;
            pend_full   <= 1'b0;
            gap_q       <= GAP_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_acc    <= csum_acc + eff_word_c;
            if (remaining == 32'd1) state <= S_CSUM;
`else
            if (remaining == 32'd1) state <= S_GAP_END;
`endif
          end else if (word_done_c) begin
            pend_word <= new_word_c;
            pend_full <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (word_done_c) begin
            checksum_err <= (new_word_c != csum_acc);
            state        <= S_GAP_END;
          end
        end
`endif

        S_GAP_END: begin
          if (gap_done_c) begin
            input_end <= 1'b1;
            byte_cnt  <= 2'd0;
            state     <= S_HDR;
          end
        end

        default: state <= S_HDR;
      endcase
    end
  end

`ifndef PROGRAM_LOADER_CHECKSUM_EN
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected loader events, a monitor pops and compares.
module tb_program_loader;

  localparam int GAP_A   = 4;
  localparam int K_START = 0;
  localparam int K_TOG   = 1;
  localparam int K_END   = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data_a, rx_data_b;
  logic        rx_valid_a, rx_valid_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, start_a, start_b, end_a, end_b, busy_a, busy_b;
  logic        ovs_a, ovs_b, ovr_a, ovr_b, cse_a, cse_b;

  program_loader #(.INST_MEM_WIDTH(2), .MIN_GAP(4)) dut_a (
    .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .input_data(data_a), .input_valid(valid_a), .input_start(start_a), .input_end(end_a),
    .busy(busy_a), .oversize(ovs_a), .overrun(ovr_a), .checksum_err(cse_a));

  program_loader #(.INST_MEM_WIDTH(2), .MIN_GAP(8)) dut_b (
    .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .input_data(data_b), .input_valid(valid_b), .input_start(start_b), .input_end(end_b),
    .busy(busy_b), .oversize(ovs_b), .overrun(ovr_b), .checksum_err(cse_b));

  logic [1:0]  m_start, m_end, m_valid, m_busy, m_ovs, m_ovr, m_cse;
  logic [31:0] m_data [2];
  assign m_start   = {start_b, start_a};
  assign m_end     = {end_b, end_a};
  assign m_valid   = {valid_b, valid_a};
  assign m_busy    = {busy_b, busy_a};
  assign m_ovs     = {ovs_b, ovs_a};
  assign m_ovr     = {ovr_b, ovr_a};
  assign m_cse     = {cse_b, cse_a};
  assign m_data[0] = data_a;
  assign m_data[1] = data_b;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exq [2][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int kind, input logic [31:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    exq[d].push_back(e);
  endtask

  task automatic observe(input int d, input int kind, input logic [31:0] data);
    exp_t e;
    n_checks++;
    if (exq[d].size() == 0) begin
      n_fail++;
      $display("FAIL event_dut%0d: got kind=%0d data=%h cyc=%0d expected no event", d, kind, data, cyc);
    end else begin
      e = exq[d].pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_TOG && e.data !== data)) begin
        n_fail++;
        $display("FAIL event_dut%0d: got kind=%0d data=%h cyc=%0d expected kind=%0d data=%h cyc=%0d",
                 d, kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Watches both DUTs on the falling edge; reset suppresses toggle detection.
  task automatic monitor();
    logic [1:0] pv;
    pv = 2'b00;
    forever begin
      @(negedge CLK);
      if (!reset_n) begin
        pv = 2'b00;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (m_start[d])          observe(d, K_START, 32'd0);
          if (m_valid[d] != pv[d]) observe(d, K_TOG, m_data[d]);
          if (m_end[d])            observe(d, K_END, 32'd0);
        end
        pv = m_valid;
      end
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int idle, output int c);
    repeat (idle) begin @(posedge CLK); #1; end
    if (sel == 0) begin rx_data_a = b; rx_valid_a = 1'b1; end
    else          begin rx_data_b = b; rx_valid_b = 1'b1; end
    c = cyc;
    @(posedge CLK); #1;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int idle, output int c);
    for (int i = 3; i >= 0; i--) send_byte(sel, w[8*i +: 8], idle, c);
  endtask

  // Spec timing model for a load on dut_a without overruns.
  task automatic run_load(input logic [31:0] n, input logic [31:0] w [8], input int idle,
                          input logic [31:0] trailer);
    int t, u, last, fin;
    send_word(0, n, idle, t);
    push(0, K_START, 32'd0, t + 1);
    last = t + 1;
    for (int i = 0; i < int'(n); i++) begin
      send_word(0, w[i], idle, u);
      last = (u + 1 > last + GAP_A) ? u + 1 : last + GAP_A;
      push(0, K_TOG, w[i], last);
    end
    fin = last + GAP_A;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (n != 32'd0) begin
      send_word(0, trailer, idle, u);
      if (u + 2 > fin) fin = u + 2;
    end
`endif
    push(0, K_END, 32'd0, fin);
  endtask

  task automatic wait_idle(input int d, input string tag);
    int k;
    k = 0;
    while (m_busy[d] && k < 500) begin @(posedge CLK); #1; k++; end
    chk({tag, "_idle"}, 32'(m_busy[d]), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exq[d].size()), 32'd0);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    chk({tag, "_data"},  m_data[d], 32'd0);
    chk({tag, "_valid"}, 32'(m_valid[d]), 32'd0);
    chk({tag, "_start"}, 32'(m_start[d]), 32'd0);
    chk({tag, "_end"},   32'(m_end[d]), 32'd0);
    chk({tag, "_busy"},  32'(m_busy[d]), 32'd0);
    chk({tag, "_ovs"},   32'(m_ovs[d]), 32'd0);
    chk({tag, "_ovr"},   32'(m_ovr[d]), 32'd0);
    chk({tag, "_cse"},   32'(m_cse[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] wv [8];
    int t, u;
    reset_n    = 1'b0;
    rx_data_a  = 8'd0;
    rx_data_b  = 8'd0;
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals(0, "rst");
    reset_n = 1'b1;
    @(posedge CLK); #1;

    // Two words, bytes 20 cycles apart.
    wv = '{32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 0};
    run_load(32'd2, wv, 19, 32'hACF13568);
    wait_idle(0, "two_words");
    chk("two_words_data",  data_a, 32'h9ABCDEF0);
    chk("two_words_valid", 32'(valid_a), 32'd0);
    chk("two_words_ovs",   32'(ovs_a), 32'd0);
    chk("two_words_ovr",   32'(ovr_a), 32'd0);
    chk("two_words_cse",   32'(cse_a), 32'd0);

    // Empty program: start then end MIN_GAP later, no toggle.
    run_load(32'd0, wv, 3, 32'd0);
    wait_idle(0, "empty");
    chk("empty_valid", 32'(valid_a), 32'd0);

    // One word back-to-back: toggle deferred to start+MIN_GAP.
    wv = '{32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0};
    run_load(32'd1, wv, 0, 32'hCAFEF00D);
    wait_idle(0, "b2b");
    chk("b2b_data",  data_a, 32'hCAFEF00D);
    chk("b2b_valid", 32'(valid_a), 32'd1);
    chk("b2b_ovr",   32'(ovr_a), 32'd0);

    // Five words into a four-word memory.
    wv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 0, 0, 0};
    run_load(32'd5, wv, 2, 32'hFFFFFFFF);
    wait_idle(0, "oversize");
    chk("oversize_flag",  32'(ovs_a), 32'd1);
    chk("oversize_data",  data_a, 32'h55555555);
    chk("oversize_valid", 32'(valid_a), 32'd0);

    // Words 1, 2 with a good trailer; sticky oversize clears at start.
    wv = '{32'd1, 32'd2, 0, 0, 0, 0, 0, 0};
    run_load(32'd2, wv, 1, 32'd3);
    wait_idle(0, "csum_ok");
    chk("csum_ok_cse",  32'(cse_a), 32'd0);
    chk("csum_ok_ovs",  32'(ovs_a), 32'd0);
    chk("csum_ok_data", data_a, 32'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    run_load(32'd2, wv, 1, 32'd4);
    wait_idle(0, "csum_bad");
    chk("csum_bad_cse",  32'(cse_a), 32'd1);
    chk("csum_bad_data", data_a, 32'd2);
`endif

    // MIN_GAP=8, three words back-to-back: second word overruns the first.
    send_word(1, 32'd3, 0, t);
    push(1, K_START, 32'd0, t + 1);
    push(1, K_TOG, 32'hB0B0B0B2, t + 9);
    push(1, K_TOG, 32'hB0B0B0B3, t + 17);
    send_word(1, 32'hB0B0B0B1, 0, u);
    send_word(1, 32'hB0B0B0B2, 0, u);
    send_word(1, 32'hB0B0B0B3, 0, u);
    while (cyc < t + 20) begin @(posedge CLK); #1; end
    chk("overrun_flag",  32'(ovr_b), 32'd1);
    chk("overrun_data",  data_b, 32'hB0B0B0B3);
    chk("overrun_valid", 32'(valid_b), 32'd0);
    chk("overrun_busy",  32'(busy_b), 32'd1);
    chk("overrun_queue_empty", 32'(exq[1].size()), 32'd0);

    // Asynchronous reset mid-load: outputs clear before the next edge.
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals(1, "midrst");
    repeat (2) @(posedge CLK);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    chk("midrst_no_end", 32'(exq[1].size()), 32'd0);
    chk("midrst_busy_after", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
